// File: rtl/wb_uart_tx.sv
// Wishbone classic UART transmitter with a byte FIFO (8N1 by default).
// Define WB_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
module wb_uart_tx #(
  parameter int unsigned CLK_FREQ_HZ = 24000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_AW     = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [2:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        tx_o
);

  localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned LVL_W = FIFO_AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

`ifdef WB_UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q;
  logic               overflow_q;
  logic               ack_q;
  logic [31:0]        dat_o_q;
  logic               tx_q;
  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         bit_q;
  logic [7:0]         shift_q;
`ifdef WB_UART_TX_PARITY_EN
  logic               parity_q;
`endif

  logic        access, wr_data, wr_status, rd_status;
  logic        fifo_full, fifo_empty, push, pop, baud_tick;
  logic [31:0] status;

  // Only byte 0 of DATA, bit 3 of STATUS and address bit 2 carry meaning.
  logic unused_ok;
  assign unused_ok = ^{wb_dat_i[31:8], wb_sel_i[3:1], wb_adr_i[1:0]};

  always_comb begin
    access     = wb_cyc_i & wb_stb_i & ~ack_q;
    wr_data    = access & wb_we_i & ~wb_adr_i[2] & wb_sel_i[0];
    wr_status  = access & wb_we_i & wb_adr_i[2];
    rd_status  = access & ~wb_we_i & wb_adr_i[2];
    fifo_full  = (level_q == FULL_LVL);
    fifo_empty = (level_q == '0);
    push       = wr_data & ~fifo_full;
    baud_tick  = (cnt_q == CNT_MAX);
    // Pops happen only when a new frame is launched: from idle, or straight out of stop.
    pop        = ~fifo_empty & ((state_q == StIdle) | ((state_q == StStop) & baud_tick));
    status     = '0;
    status[0]  = (state_q != StIdle);
    status[1]  = fifo_full;
    status[2]  = fifo_empty;
    status[3]  = overflow_q;
    status[8 +: LVL_W] = level_q;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wb_dat_i[7:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      ack_q      <= 1'b0;
      dat_o_q    <= '0;
      tx_q       <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
`ifdef WB_UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      ack_q   <= access;
      dat_o_q <= rd_status ? status : '0;

      if (push) begin
        wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
        shift_q  <= mem_q[rd_ptr_q];
`ifdef WB_UART_TX_PARITY_EN
        parity_q <= ^mem_q[rd_ptr_q];
`endif
      end
      level_q <= level_q + LVL_W'(push) - LVL_W'(pop);

      if (wr_status && wb_dat_i[3]) begin
        overflow_q <= 1'b0;
      end else if (wr_data && fifo_full) begin
        overflow_q <= 1'b1;
      end

      cnt_q <= ((state_q == StIdle) || baud_tick) ? '0 : cnt_q + CNT_W'(1);

      // tx_q follows the state one clock late, so every state lasts DIV clocks on the line.
      unique case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (pop) begin
            state_q <= StStart;
          end
        end
        StStart: begin
          tx_q <= 1'b0;
          if (baud_tick) begin
            state_q <= StData;
            bit_q   <= '0;
          end
        end
        StData: begin
          tx_q <= shift_q[0];
          if (baud_tick) begin
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef WB_UART_TX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end
          end
        end
`ifdef WB_UART_TX_PARITY_EN
        StParity: begin
          tx_q <= parity_q;
          if (baud_tick) begin
            state_q <= StStop;
          end
        end
`endif
        StStop: begin
          tx_q <= 1'b1;
          if (baud_tick) begin
            state_q <= pop ? StStart : StIdle;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_o_q;
  assign tx_o     = tx_q;

endmodule

// File: doc/wb_uart_tx.md
WB_UART_TX -- requirements
Module: wb_uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 24000000, wishbone clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL have parameter FIFO_AW, default 4, FIFO address width; depth = 2^FIFO_AW bytes.
REQ-004 SHALL have port clock, input, 1, the single clock; all logic is rising-edge on it.
REQ-005 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-006 SHALL have port wb_adr_i, input, 3, byte address; only bit 2 decodes (0 = DATA, 1 = STATUS).
REQ-007 SHALL have port wb_dat_i, input, 32, write data.
REQ-008 SHALL have port wb_dat_o, output, 32, read data.
REQ-009 SHALL have port wb_sel_i, input, 4, byte selects; a DATA write requires wb_sel_i[0].
REQ-010 SHALL have ports wb_we_i, wb_cyc_i and wb_stb_i, input, 1 each, Wishbone classic controls.
REQ-011 SHALL have port wb_ack_o, output, 1, cycle acknowledge.
REQ-012 SHALL have port tx_o, output, 1, serial line, idle high.

Function
REQ-013 SHALL compute DIV = CLK_FREQ_HZ / BAUD with integer truncation (208 at defaults); every bit on tx_o lasts exactly DIV clocks.
REQ-014 SHALL register wb_ack_o high for one clock when wb_cyc_i & wb_stb_i & ~wb_ack_o; one access completes per two clocks; wb_ack_o never asserts without wb_cyc_i & wb_stb_i.
REQ-015 SHALL commit a write on the clock edge that sets wb_ack_o.
REQ-016 On a DATA write with wb_sel_i[0], SHALL push wb_dat_i[7:0] into the FIFO if the FIFO is not full at that edge.
REQ-017 On a DATA write when the FIFO is full, SHALL drop the byte and set sticky overflow, even if a pop occurs on the same edge.
REQ-018 SHALL return 0 on a DATA read.
REQ-019 STATUS read SHALL return: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow, bits[8+FIFO_AW:8] FIFO level (0..2^FIFO_AW), all other bits 0.
REQ-020 A STATUS write with wb_dat_i[3]=1 SHALL clear overflow; all other STATUS write bits are ignored.
REQ-021 SHALL implement the FSM states IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-022 IDLE->START: when the FIFO is non-empty, pop one byte; tx_o falls exactly 2 clocks after the commit edge of a write into an empty FIFO while in IDLE.
REQ-023 START->DATA: after DIV clocks; DATA shifts 8 bits LSB first, DIV clocks each, then goes to PARITY or STOP.
REQ-024 STOP: drive tx_o high for DIV clocks, then go to START with an immediate pop if the FIFO is non-empty (no idle gap), else go to IDLE.
REQ-025 A simultaneous push and pop SHALL leave the level unchanged; pointers SHALL wrap modulo 2^FIFO_AW.

Reset
REQ-026 When resetn is sampled low, SHALL set, on that edge: tx_o=1, wb_ack_o=0, wb_dat_o=0, FSM=IDLE, FIFO empty (level 0), overflow=0, baud counter=0.
REQ-027 A reset mid-frame SHALL abort the frame; tx_o is high the clock after resetn is sampled low, and the aborted byte is discarded.

Configuration
REQ-028 Macro WB_UART_TX_PARITY_EN defined SHALL insert the PARITY state between DATA and STOP, driving even parity (XOR of the 8 data bits) for DIV clocks; the frame is 11*DIV clocks.
REQ-029 Macro WB_UART_TX_PARITY_EN undefined SHALL remove the PARITY state and parity logic; the frame is 8N1, 10*DIV clocks.

Verification (bench: CLK_FREQ_HZ=1000000, BAUD=100000, DIV=10, FIFO_AW=2)
REQ-030 Write DATA 0x55 while idle -> tx_o low 2 clocks after the ack edge, then 1,0,1,0,1,0,1,0 then stop 1, 10 clocks each; STATUS reads 0x00000004 afterwards.
REQ-031 Write 0xA0, 0x0F back-to-back -> the second start bit begins the clock after the first stop bit ends; no idle gap.
REQ-032 Write 6 bytes while the first frame is active -> first 5 are sent in order; 6th is dropped; STATUS bit3=1 and bit1=1; STATUS write 0x8 -> bit3=0.
REQ-033 Assert resetn=0 for 1 clock during the DATA state of 0x33 -> tx_o=1 next clock, STATUS=0x00000004, nothing further transmitted.
REQ-034 With WB_UART_TX_PARITY_EN, write 0x07 -> parity bit 1, frame 110 clocks; without the macro the same write gives a 100-clock frame.
REQ-035 Hold wb_cyc_i & wb_stb_i high for 6 clocks on STATUS -> wb_ack_o alternates 0,1,0,1,0,1.
